// File: rtl/csr_bus_router.sv
// csr_bus_router
//   Registered CSR request router between the core CSR unit and NUM_TGT CSR
//   targets. A request is decoded against per-target inclusive [base, limit]
//   windows on csr_addr[11:0]. The router issues a one-cycle strobe to the hit
//   target, waits for that target's response, and returns it under a
//   valid/ready handshake. A request that hits no window gets an exception
//   response, and no target sees it. Only one transaction is outstanding at a time.
//
//   Optional feature macro: CSR_BUS_TIMEOUT_EN. When it is defined, a WAIT
//   that lasts TIMEOUT_CYC cycles ends in an exception response.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   csr_valid / csr_ready      upstream request handshake (ready only in IDLE)
//   csr_op, csr_funct3,
//   csr_imm, rs1_val, csr_addr request fields
//   csr_rvalid / csr_rrsp      upstream response handshake
//   csr_rdata, csr_reg_rsp     response data (0 on exception) and status (1 = exception)
//   tgt_reg_en                 one-hot, one-cycle request strobe
//   tgt_addr, tgt_reg_op,
//   tgt_funct3, tgt_csr_imm,
//   tgt_rs1_val                registered request fields broadcast to all targets
//   tgt_rvalid, tgt_rdata,
//   tgt_act_rsp                per-target response valid, data and status
//   tgt_rrsp                   one-hot acknowledge of the sampled target response

module csr_bus_router #(
    parameter int unsigned              ADDR_WIDTH  = 32,
    parameter int unsigned              REG_WIDTH   = 32,
    parameter int unsigned              NUM_TGT     = 4,
    parameter logic [NUM_TGT*12-1:0]    TGT_BASE    = {NUM_TGT{12'h0}},
    parameter logic [NUM_TGT*12-1:0]    TGT_LIMIT   = {NUM_TGT{12'h0}},
    parameter int unsigned              TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          csr_valid,
    output logic                          csr_ready,
    input  logic [1:0]                    csr_op,
    input  logic [2:0]                    csr_funct3,
    input  logic [4:0]                    csr_imm,
    input  logic [REG_WIDTH-1:0]          rs1_val,
    input  logic [ADDR_WIDTH-1:0]         csr_addr,
    output logic                          csr_rvalid,
    input  logic                          csr_rrsp,
    output logic [REG_WIDTH-1:0]          csr_rdata,
    output logic                          csr_reg_rsp,
    output logic [NUM_TGT-1:0]            tgt_reg_en,
    output logic [ADDR_WIDTH-1:0]         tgt_addr,
    output logic [1:0]                    tgt_reg_op,
    output logic [2:0]                    tgt_funct3,
    output logic [4:0]                    tgt_csr_imm,
    output logic [REG_WIDTH-1:0]          tgt_rs1_val,
    input  logic [NUM_TGT-1:0]            tgt_rvalid,
    input  logic [NUM_TGT*REG_WIDTH-1:0]  tgt_rdata,
    input  logic [NUM_TGT-1:0]            tgt_act_rsp,
    output logic [NUM_TGT-1:0]            tgt_rrsp
);

    localparam int unsigned SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SEL_W-1:0]       sel_q;
    logic [REG_WIDTH-1:0]   rdata_q;
    logic                   rsp_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic             upper_zero;
    logic             hit;
    logic [SEL_W-1:0] hit_idx;

    generate
        if (ADDR_WIDTH > 12) begin : g_upper
            assign upper_zero = (csr_addr[ADDR_WIDTH-1:12] == '0);
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
    endgenerate

    // Scan in ascending order and keep the first hit, so the lowest index
    // wins when windows overlap. A window whose base is above its limit
    // cannot satisfy both compares, so it never hits.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_TGT; i++) begin
            if (!hit && upper_zero &&
                (csr_addr[11:0] >= TGT_BASE[i*12 +: 12]) &&
                (csr_addr[11:0] <= TGT_LIMIT[i*12 +: 12])) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Selected-target response
    // ------------------------------------------------------------------
    logic                 sel_rvalid;
    logic                 sel_act;
    logic [REG_WIDTH-1:0] sel_rdata;

    assign sel_rvalid = tgt_rvalid[sel_q];
    assign sel_act    = tgt_act_rsp[sel_q];
    assign sel_rdata  = tgt_rdata[sel_q*REG_WIDTH +: REG_WIDTH];

    // ------------------------------------------------------------------
    // Optional WAIT timeout
    // ------------------------------------------------------------------
    logic timed_out;

`ifdef CSR_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    // wait_cnt is 0 in the first WAIT cycle, so reaching TIMEOUT_CYC-1
    // marks the last allowed WAIT cycle.
    assign timed_out = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (csr_valid) begin
                    state_nxt = hit ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A target response in the timeout cycle takes priority.
                if (sel_rvalid || timed_out) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (csr_rrsp) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= '0;
            tgt_addr    <= '0;
            tgt_reg_op  <= '0;
            tgt_funct3  <= '0;
            tgt_csr_imm <= '0;
            tgt_rs1_val <= '0;
            rdata_q     <= '0;
            rsp_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (csr_valid) begin
                        sel_q       <= hit_idx;
                        tgt_addr    <= csr_addr;
                        tgt_reg_op  <= csr_op;
                        tgt_funct3  <= csr_funct3;
                        tgt_csr_imm <= csr_imm;
                        tgt_rs1_val <= rs1_val;
                        rdata_q     <= '0;
                        rsp_q       <= ~hit;
                    end
                end
                ST_WAIT: begin
                    if (sel_rvalid) begin
                        rdata_q <= sel_act ? '0 : sel_rdata;
                        rsp_q   <= sel_act;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        rsp_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign csr_ready   = (state == ST_IDLE);
    assign csr_rvalid  = (state == ST_RESP);
    assign csr_rdata   = (state == ST_RESP) ? rdata_q : '0;
    assign csr_reg_rsp = (state == ST_RESP) ? rsp_q : 1'b0;

    always_comb begin
        tgt_reg_en = '0;
        tgt_rrsp   = '0;
        if (state == ST_ISSUE) begin
            tgt_reg_en[sel_q] = 1'b1;
        end
        if ((state == ST_WAIT) && sel_rvalid) begin
            tgt_rrsp[sel_q] = 1'b1;
        end
    end

endmodule
